scene_fetch: RTL and testbench

Avalon-MM read front end for the ray tracer. On `start`, it fetches one ray, a 32-bit triangle count and then that many triangles from memory over a 16-bit master port. It assembles 32-bit fixed-point words from little-endian halfword pairs and streams complete triangle records, with a valid/ready handshake, to the downstream triangle intersector.

---
 rtl/rt_pkg.sv | 36 +++
 rtl/scene_fetch_if.sv | 19 +
 rtl/avm_read_issuer.sv | 62 ++++++
 rtl/scene_fetch.sv | 190 +++++++++++++++++++
 tb/tb_scene_fetch.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rt_pkg.sv
// Shared types and constants for the ray tracer scene fetch path.
package rt_pkg;

  typedef logic signed [31:0] fixed_t;  // Q16.16

  typedef struct packed {
    fixed_t z;
    fixed_t y;
    fixed_t x;
  } vec3_t;

  typedef struct packed {
    vec3_t dir;
    vec3_t orig;
  } ray_t;

  typedef struct packed {
    vec3_t v2;
    vec3_t v1;
    vec3_t v0;
  } tri_t;

  localparam int unsigned RAY_HWORDS = 12;
  localparam int unsigned CNT_HWORDS = 2;
  localparam int unsigned TRI_HWORDS = 18;

  typedef enum logic [2:0] {
    StIdle,
    StRay,
    StCnt,
    StTri,
    StHold,
    StDone
  } fetch_state_e;

endpackage

// File: rtl/scene_fetch_if.sv
// Avalon-MM 16-bit read master bus used by scene_fetch.
interface scene_fetch_if;
  logic        avm_m0_read;
  logic [31:0] avm_m0_address;
  logic [1:0]  avm_m0_byteenable;
  logic        avm_m0_waitrequest;
  logic [15:0] avm_m0_readdata;
  logic        avm_m0_readdatavalid;

  modport master (
    output avm_m0_read, avm_m0_address, avm_m0_byteenable,
    input  avm_m0_waitrequest, avm_m0_readdata, avm_m0_readdatavalid
  );

  modport slave (
    input  avm_m0_read, avm_m0_address, avm_m0_byteenable,
    output avm_m0_waitrequest, avm_m0_readdata, avm_m0_readdatavalid
  );
endinterface

// File: rtl/avm_read_issuer.sv
// Read request generator: address counter, per-record request count and outstanding limit.
module avm_read_issuer #(
  parameter int unsigned MAX_PEND = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] load_addr_i,
  input  logic        active_i,
  input  logic [4:0]  rec_len_i,
  input  logic        rec_done_i,
  input  logic        rsp_i,
  input  logic        waitrequest_i,
  output logic        read_o,
  output logic [31:0] address_o
);

  logic [31:0] addr_q, addr_d;
  logic [4:0]  req_q, req_d;
  logic [3:0]  pend_q, pend_d;
  logic        accept;

  // Inputs to read_o only move on acceptance or response, so a stalled request holds.
  always_comb begin
    read_o = active_i && (req_q < rec_len_i) && (pend_q < 4'(MAX_PEND));
    accept = read_o && !waitrequest_i;
    addr_d = addr_q;
    req_d  = req_q;
    pend_d = pend_q;
    if (load_i) begin
      addr_d = load_addr_i;
      req_d  = '0;
      pend_d = '0;
    end else begin
      if (accept) begin
        addr_d = addr_q + 32'd2;
        req_d  = req_q + 5'd1;
      end
      if (rec_done_i) req_d = '0;
      if (accept && !rsp_i) begin
        pend_d = pend_q + 4'd1;
      end else if (!accept && rsp_i) begin
        pend_d = pend_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q <= '0;
      req_q  <= '0;
      pend_q <= '0;
    end else begin
      addr_q <= addr_d;
      req_q  <= req_d;
      pend_q <= pend_d;
    end
  end

  assign address_o = addr_q;

endmodule

// File: rtl/scene_fetch.sv
// Scene fetch front end: reads ray, count and triangles, streams triangle records.
// Define SCENE_FETCH_PREFETCH_EN to fetch triangle n+1 while triangle n is held.
module scene_fetch
  import rt_pkg::*;
#(
  parameter int unsigned MAX_PEND = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  scene_fetch_if.master        avm,
  output logic [191:0]         o_ray,
  output logic                 o_ray_valid,
  output logic [287:0]         o_tri,
  output logic [31:0]          o_tri_index,
  output logic                 o_tri_valid,
  input  logic                 i_tri_ready,
  output logic                 o_tri_last,
  output logic [31:0]          o_tri_cnt,
  output logic                 o_busy,
  output logic                 o_done
);

  fetch_state_e state_q, state_d;
  logic [4:0]   recv_q, recv_d;
  logic [287:0] rec_q, rec_d;
  ray_t         ray_q, ray_d;
  tri_t         tri_q, tri_d;
  logic         ray_valid_q, ray_valid_d, tri_valid_q, tri_valid_d;
  logic [31:0]  cnt_q, cnt_d, tri_idx_q, tri_idx_d, fetched_q, fetched_d;
`ifdef SCENE_FETCH_PREFETCH_EN
  logic         buf_full_q, buf_full_d;
`endif
  logic [4:0]   rec_len;
  logic         fetching, take, last_hw, handshake, is_last, load;

  always_comb begin
    unique case (state_q)
      StRay:   rec_len = 5'(RAY_HWORDS);
      StCnt:   rec_len = 5'(CNT_HWORDS);
      default: rec_len = 5'(TRI_HWORDS);
    endcase
  end

  assign fetching = (state_q == StRay) || (state_q == StCnt) || (state_q == StTri)
`ifdef SCENE_FETCH_PREFETCH_EN
                    || ((state_q == StHold) && !buf_full_q && (fetched_q < cnt_q))
`endif
                    ;
  assign take      = fetching && avm.avm_m0_readdatavalid;
  assign last_hw   = take && (recv_q == rec_len - 5'd1);
  assign handshake = tri_valid_q && i_tri_ready;
  assign is_last   = (tri_idx_q == cnt_q - 32'd1);
  assign load      = (state_q == StIdle) && start;

  avm_read_issuer #(.MAX_PEND(MAX_PEND)) u_issuer (
    .clk           (clk),
    .reset         (reset),
    .load_i        (load),
    .load_addr_i   (base_addr),
    .active_i      (fetching),
    .rec_len_i     (rec_len),
    .rec_done_i    (last_hw),
    .rsp_i         (take),
    .waitrequest_i (avm.avm_m0_waitrequest),
    .read_o        (avm.avm_m0_read),
    .address_o     (avm.avm_m0_address)
  );

  always_comb begin
    state_d     = state_q;
    recv_d      = recv_q;
    rec_d       = rec_q;
    ray_d       = ray_q;
    ray_valid_d = ray_valid_q;
    cnt_d       = cnt_q;
    tri_d       = tri_q;
    tri_valid_d = tri_valid_q;
    tri_idx_d   = tri_idx_q;
    fetched_d   = fetched_q;
`ifdef SCENE_FETCH_PREFETCH_EN
    buf_full_d  = buf_full_q;
`endif
    if (take) begin
      rec_d[{recv_q, 4'd0} +: 16] = avm.avm_m0_readdata;
      recv_d = last_hw ? 5'd0 : recv_q + 5'd1;
    end
    case (state_q)
      StIdle: if (start) begin
        state_d     = StRay;
        ray_valid_d = 1'b0;
        cnt_d       = '0;
        tri_idx_d   = '0;
        fetched_d   = '0;
        recv_d      = '0;
      end
      StRay: if (last_hw) begin
        ray_d       = rec_d[191:0];
        ray_valid_d = 1'b1;
        state_d     = StCnt;
      end
      StCnt: if (last_hw) begin
        cnt_d   = rec_d[31:0];
        state_d = (rec_d[31:0] == 32'd0) ? StDone : StTri;
      end
      StTri: if (last_hw) begin
        tri_d       = rec_d;
        tri_valid_d = 1'b1;
        tri_idx_d   = fetched_q;
        fetched_d   = fetched_q + 32'd1;
        state_d     = StHold;
      end
      StHold: begin
`ifdef SCENE_FETCH_PREFETCH_EN
        if (last_hw) begin
          buf_full_d = 1'b1;
          fetched_d  = fetched_q + 32'd1;
        end
`endif
        if (handshake) begin
          tri_valid_d = 1'b0;
          if (is_last) begin
            state_d = StDone;
          end else begin
`ifdef SCENE_FETCH_PREFETCH_EN
            // Buffered (or just-completed) record goes straight out with no bubble.
            if (buf_full_q || last_hw) begin
              tri_d       = rec_d;
              tri_valid_d = 1'b1;
              tri_idx_d   = tri_idx_q + 32'd1;
              buf_full_d  = 1'b0;
            end else begin
              state_d = StTri;
            end
`else
            state_d = StTri;
`endif
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      recv_q      <= '0;
      rec_q       <= '0;
      ray_q       <= '0;
      ray_valid_q <= 1'b0;
      cnt_q       <= '0;
      tri_q       <= '0;
      tri_valid_q <= 1'b0;
      tri_idx_q   <= '0;
      fetched_q   <= '0;
`ifdef SCENE_FETCH_PREFETCH_EN
      buf_full_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      recv_q      <= recv_d;
      rec_q       <= rec_d;
      ray_q       <= ray_d;
      ray_valid_q <= ray_valid_d;
      cnt_q       <= cnt_d;
      tri_q       <= tri_d;
      tri_valid_q <= tri_valid_d;
      tri_idx_q   <= tri_idx_d;
      fetched_q   <= fetched_d;
`ifdef SCENE_FETCH_PREFETCH_EN
      buf_full_q  <= buf_full_d;
`endif
    end
  end

  assign avm.avm_m0_byteenable = 2'b11;
  assign o_ray       = ray_q;
  assign o_ray_valid = ray_valid_q;
  assign o_tri       = tri_q;
  assign o_tri_index = tri_idx_q;
  assign o_tri_valid = tri_valid_q;
  assign o_tri_last  = tri_valid_q && is_last;
  assign o_tri_cnt   = cnt_q;
  assign o_busy      = (state_q != StIdle);
  assign o_done      = (state_q == StDone);

endmodule

// File: tb/tb_scene_fetch.sv
// Self-checking bench for scene_fetch: memory slave model, scene table and scoreboard.
module tb_scene_fetch;
  import rt_pkg::*;

  localparam int unsigned MaxPend = 4;

  logic         clk, reset, start, i_tri_ready;
  logic [31:0]  base_addr;
  logic [191:0] o_ray;
  logic [287:0] o_tri;
  logic [31:0]  o_tri_index, o_tri_cnt;
  logic         o_ray_valid, o_tri_valid, o_tri_last, o_busy, o_done;

  scene_fetch_if avm ();

  scene_fetch #(.MAX_PEND(MaxPend)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .avm         (avm),
    .o_ray       (o_ray),
    .o_ray_valid (o_ray_valid),
    .o_tri       (o_tri),
    .o_tri_index (o_tri_index),
    .o_tri_valid (o_tri_valid),
    .i_tri_ready (i_tri_ready),
    .o_tri_last  (o_tri_last),
    .o_tri_cnt   (o_tri_cnt),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    int          cnt;
    int          wait_pct;
    int          lat;
    int          stall;      // 0 none, 1 stall tri 1 + back-to-back check, 2 stall only
    bit          restart;
    int          exp_reads;
  } vec_t;
  typedef struct { int due; logic [15:0] data; } rsp_t;
  typedef struct { tri_t data; logic [31:0] idx; logic last; } sb_t;

  logic [15:0] mem [int unsigned];
  rsp_t        rsp_q[$];
  sb_t         sb_q[$];
  vec_t        vecs[6];

  int n_vec = 0, n_fail = 0;
  int ncyc = 0, pend = 0, stale_n = 0, rsp_scene = 0, n_reads = 0, done_n = 0, tri_n = 0;
  int wait_pct = 0, lat = 2, stall_mode = 0, stall_left = 0;
  bit stalled_once, valid_seen, ray_next, prev_stall, prev_hold, hs_prev, b2b_pend;
  logic [31:0]  exp_addr, prev_addr, prev_idx;
  logic         prev_last;
  logic [287:0] prev_tri;
  ray_t         exp_ray;

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    mem[a >> 1]       = w[15:0];
    mem[(a >> 1) + 1] = w[31:16];
  endtask

  // Slave model, ready driver and monitors, all sampled mid-cycle.
  initial begin
    rsp_t r;
    sb_t  it;
    avm.avm_m0_waitrequest   = 1'b0;
    avm.avm_m0_readdatavalid = 1'b0;
    avm.avm_m0_readdata      = '0;
    i_tri_ready              = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      ncyc++;
      if (!reset) begin
        stale_n = rsp_q.size();
        pend    = 0;
      end
      if (reset && ray_next) begin
        chk("ray_valid_rise", o_ray_valid, 1);
        ray_next = 0;
      end
      avm.avm_m0_readdatavalid = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0].due <= ncyc) begin
        r = rsp_q.pop_front();
        avm.avm_m0_readdatavalid = 1'b1;
        avm.avm_m0_readdata      = r.data;
        if (stale_n > 0) stale_n--;
        else begin
          pend--;
          rsp_scene++;
          if (rsp_scene == 12 && reset) begin
            chk("ray_valid_pre", o_ray_valid, 0);
            ray_next = 1;
          end
        end
      end
      avm.avm_m0_waitrequest = ($urandom_range(99) < wait_pct);
      if (reset && stall_mode != 0 && !stalled_once && o_tri_valid && o_tri_index == 32'd1) begin
        stalled_once = 1;
        stall_left   = 20;
      end
      if (stall_left > 0) begin
        i_tri_ready = 1'b0;
        stall_left--;
      end else begin
        i_tri_ready = 1'b1;
      end
      if (reset) begin
        if (prev_stall) chk("stall_hold", {avm.avm_m0_read, avm.avm_m0_address}, {1'b1, prev_addr});
        if (avm.avm_m0_read && !avm.avm_m0_waitrequest) begin
          chk("rd_addr", avm.avm_m0_address, exp_addr);
          exp_addr += 32'd2;
          n_reads++;
          r.due  = ncyc + lat;
          r.data = mem.exists(avm.avm_m0_address >> 1) ? mem[avm.avm_m0_address >> 1] : 16'h0;
          rsp_q.push_back(r);
          pend++;
          chk("outstanding", pend <= int'(MaxPend), 1);
        end
        if (prev_hold) begin
          chk("tri_hold_data", o_tri, prev_tri);
          chk("tri_hold_ctl", {o_tri_valid, o_tri_last, o_tri_index}, {1'b1, prev_last, prev_idx});
        end
`ifdef SCENE_FETCH_PREFETCH_EN
        if (hs_prev && b2b_pend) begin
          chk("b2b_next", {o_tri_valid, o_tri_index}, {1'b1, 32'd2});
          b2b_pend = 0;
        end
`else
        if (hs_prev) chk("valid_fall", o_tri_valid, 0);
`endif
        if (o_tri_valid) valid_seen = 1;
        if (o_tri_valid && i_tri_ready) begin
          tri_n++;
          if (sb_q.size() == 0) begin
            chk("unexpected_tri", o_tri_index, 32'hFFFF_FFFF);
          end else begin
            it = sb_q.pop_front();
            chk("tri_data", o_tri, it.data);
            chk("tri_index", o_tri_index, it.idx);
            chk("tri_last", o_tri_last, it.last);
          end
`ifdef SCENE_FETCH_PREFETCH_EN
          if (stall_mode == 1 && o_tri_index == 32'd1) b2b_pend = 1;
`endif
        end
        if (o_done) done_n++;
      end
      prev_stall = reset && avm.avm_m0_read && avm.avm_m0_waitrequest;
      prev_addr  = avm.avm_m0_address;
      prev_hold  = reset && o_tri_valid && !i_tri_ready;
      hs_prev    = reset && o_tri_valid && i_tri_ready;
      prev_tri   = o_tri;
      prev_idx   = o_tri_index;
      prev_last  = o_tri_last;
    end
  end

  task automatic begin_scene(input vec_t v, input bit fixed_data);
    ray_t r;
    tri_t t;
    sb_t  it;
    if (fixed_data) begin
      r.orig = '{z: 32'sd65536, y: 32'sd0, x: 32'sd0};
      r.dir  = '{z: -32'sd65536, y: 32'sd0, x: 32'sd0};
    end else begin
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    for (int j = 0; j < 6; j++) put_word(v.base + 32'(4 * j), r[32 * j +: 32]);
    put_word(v.base + 32'd24, 32'(v.cnt));
    for (int i = 0; i < v.cnt; i++) begin
      if (fixed_data) begin
        t.v0 = '{z: -32'sd131072, y: 32'sd131072, x: 32'sd0};
        t.v1 = '{z: -32'sd131072, y: 32'sd0, x: 32'(i + 1) <<< 16};
        t.v2 = '{z: -32'sd131072, y: -(32'(i + 1) <<< 16), x: 32'sd65536};
      end else begin
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom};
      end
      for (int j = 0; j < 9; j++) put_word(v.base + 32'(28 + 36 * i + 4 * j), t[32 * j +: 32]);
      it.data = t;
      it.idx  = 32'(i);
      it.last = (i == v.cnt - 1);
      sb_q.push_back(it);
    end
    exp_ray      = r;
    wait_pct     = v.wait_pct;
    lat          = v.lat;
    stall_mode   = v.stall;
    stalled_once = 0;
    valid_seen   = 0;
    exp_addr     = v.base;
    n_reads      = 0;
    done_n       = 0;
    tri_n        = 0;
    rsp_scene    = 0;
    @(negedge clk);
    base_addr = v.base;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    base_addr = $urandom;
    #2;
    chk("first_read", avm.avm_m0_read, 1);
    chk("busy", o_busy, 1);
  endtask

  task automatic run_vec(input vec_t v, input bit fixed_data);
    begin_scene(v, fixed_data);
    if (v.restart) begin
      repeat (10) @(negedge clk);
      base_addr = 32'hDEAD_0000;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
    end
    for (int i = 0; i < 5000 && done_n == 0; i++) @(negedge clk);
    chk("done_seen", done_n != 0, 1);
    repeat (4) @(negedge clk);
    #2;
    chk("done_pulses", done_n, 1);
    chk("reads", n_reads, v.exp_reads);
    chk("tri_count", tri_n, v.cnt);
    chk("valid_seen", valid_seen, v.cnt != 0);
    chk("sb_empty", sb_q.size(), 0);
    chk("ray", o_ray, exp_ray);
    chk("ray_valid", o_ray_valid, 1);
    chk("tri_cnt", o_tri_cnt, v.cnt);
    chk("busy_end", o_busy, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {o_busy, o_done, o_ray_valid, o_tri_valid, o_tri_last, avm.avm_m0_read}, 0);
    chk({tag, "_ray"}, o_ray, 0);
    chk({tag, "_tri"}, o_tri, 0);
    chk({tag, "_idx_cnt"}, {o_tri_index, o_tri_cnt}, 0);
    chk({tag, "_addr_be"}, {avm.avm_m0_address, avm.avm_m0_byteenable}, {32'h0, 2'b11});
  endtask

  initial begin
    vec_t rv;
    reset     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    vecs[0] = '{32'h0000_1000, 3, 0, 2, 0, 1'b0, 68};
    vecs[1] = '{32'h0000_2000, 0, 0, 2, 0, 1'b0, 14};
    vecs[2] = '{32'h0000_3002, 3, 50, 2, 0, 1'b0, 68};
    vecs[3] = '{32'h0000_4000, 3, 0, 1, 1, 1'b0, 68};
    vecs[4] = '{32'h0000_5000, 1, 30, 3, 0, 1'b1, 32};
    vecs[5] = '{32'h0000_6000, 4, 25, 6, 2, 1'b0, 86};
    repeat (3) @(negedge clk);
    #2;
    chk_zero("reset");
    reset = 1'b1;
    for (int k = 0; k < 6; k++) run_vec(vecs[k], k == 0);

    // Reset in the middle of triangle 1, then a fresh scene elsewhere.
    rv = '{32'h0000_7000, 3, 0, 2, 0, 1'b0, 68};
    begin_scene(rv, 1'b0);
    for (int i = 0; i < 2000 && tri_n == 0; i++) @(negedge clk);
    chk("pre_reset_tri", tri_n, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk_zero("mid_reset");
    sb_q.delete();
    for (int i = 0; i < 100 && rsp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    #2;
    chk_zero("stale");
    run_vec('{32'h0000_8000, 2, 20, 2, 0, 1'b0, 50}, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
